// File: rtl/led_pwm_pkg.sv
// rtl/led_pwm_pkg.sv - shared mode encoding for the LED PWM sequencer
// Contents: MODE_W (mode field width), mode_e (OFF/STATIC/SEQ/BREATHE).
package led_pwm_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_OFF     = 2'd0,
        MODE_STATIC  = 2'd1,
        MODE_SEQ     = 2'd2,
        MODE_BREATHE = 2'd3
    } mode_e;

endpackage

// File: rtl/led_pwm_seq_if.sv
// rtl/led_pwm_seq_if.sv - control/config/output bundle of the LED PWM sequencer
// master: drives mode, prescale_div, frames_per_step, cfg_we/step/chan/duty;
//         receives pwm_out, step_idx, frame_done.
// slave:  the sequencer side of the same signals.
interface led_pwm_seq_if #(
    parameter int CHANNELS       = 3,
    parameter int PWM_WIDTH      = 8,
    parameter int PRESCALE_WIDTH = 16,
    parameter int STEPS          = 4
);
    import led_pwm_pkg::*;

    localparam int SW = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [MODE_W-1:0]         mode;
    logic [PRESCALE_WIDTH-1:0] prescale_div;
    logic [7:0]                frames_per_step;
    logic                      cfg_we;
    logic [SW-1:0]             cfg_step;
    logic [CW-1:0]             cfg_chan;
    logic [PWM_WIDTH-1:0]      cfg_duty;
    logic [CHANNELS-1:0]       pwm_out;
    logic [SW-1:0]             step_idx;
    logic                      frame_done;

    modport master (
        output mode, prescale_div, frames_per_step, cfg_we, cfg_step, cfg_chan, cfg_duty,
        input  pwm_out, step_idx, frame_done
    );

    modport slave (
        input  mode, prescale_div, frames_per_step, cfg_we, cfg_step, cfg_chan, cfg_duty,
        output pwm_out, step_idx, frame_done
    );

endinterface

// File: rtl/led_pwm_channel.sv
// rtl/led_pwm_channel.sv - one PWM channel: frame-latched duty plus registered compare
// Ports: clk, reset_n (async active-low); i_en (0 clears duty and output at once);
//        i_load (frame wrap: latch i_duty); i_cnt (PWM counter); o_pwm (registered output).
module led_pwm_channel #(
    parameter int PWM_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_en,
    input  logic                 i_load,
    input  logic [PWM_WIDTH-1:0] i_duty,
    input  logic [PWM_WIDTH-1:0] i_cnt,
    output logic                 o_pwm
);

    logic [PWM_WIDTH-1:0] r_duty;
    logic                 r_pwm;

    // The compare uses the duty of the running frame; the new duty lands on the
    // same edge the counter returns to 0, so a frame never mixes two duties.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_duty <= '0;
            r_pwm  <= 1'b0;
        end else if (!i_en) begin
            r_duty <= '0;
            r_pwm  <= 1'b0;
        end else begin
            if (i_load) begin
                r_duty <= i_duty;
            end
            r_pwm <= (i_cnt < r_duty);
        end
    end

    assign o_pwm = r_pwm;

endmodule

// File: rtl/led_pwm_seq.sv
// rtl/led_pwm_seq.sv - multi-channel LED PWM sequencer (static, step table, breathe)
// Ports: clk, reset_n (async active-low); bus (slave): mode, prescale_div,
//        frames_per_step, cfg_we/cfg_step/cfg_chan/cfg_duty in; pwm_out, step_idx, frame_done out.
module led_pwm_seq
    import led_pwm_pkg::*;
#(
    parameter int CHANNELS       = 3,
    parameter int PWM_WIDTH      = 8,
    parameter int PRESCALE_WIDTH = 16,
    parameter int STEPS          = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    led_pwm_seq_if.slave bus
);

    localparam int SW = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [PWM_WIDTH-1:0] CNT_MAX = '1;

    mode_e                     w_mode;
    logic                      w_off, w_tick, w_wrap;
    logic                      w_step_ok, w_chan_ok;
    logic [PRESCALE_WIDTH-1:0] r_pre;
    logic [PWM_WIDTH-1:0]      r_cnt;
    logic [PWM_WIDTH-1:0]      r_ramp, w_ramp_next;
    logic                      r_ramp_down, w_ramp_down_next;
    logic [7:0]                r_fcnt, w_fcnt_next;
    logic [SW-1:0]             r_step, w_step_next;
    mode_e                     r_mode;
    logic                      r_frame_done;
    logic [PWM_WIDTH-1:0]      r_table [STEPS][CHANNELS];
    logic [CHANNELS-1:0]       w_pwm;

    assign w_mode = mode_e'(bus.mode);
    assign w_off  = (w_mode == MODE_OFF);
    // Equality (not >=) so a lowered prescale_div lets the counter run through its wrap.
    assign w_tick = !w_off && (r_pre == bus.prescale_div);
    assign w_wrap = w_tick && (r_cnt == CNT_MAX);

    // Address checks only matter when the address field can encode unused slots.
    if (STEPS == (1 << SW)) begin : g_step_full
        assign w_step_ok = 1'b1;
    end else begin : g_step_part
        assign w_step_ok = (bus.cfg_step < SW'(STEPS));
    end
    if (CHANNELS == (1 << CW)) begin : g_chan_full
        assign w_chan_ok = 1'b1;
    end else begin : g_chan_part
        assign w_chan_ok = (bus.cfg_chan < CW'(CHANNELS));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < STEPS; s++) begin
                for (int c = 0; c < CHANNELS; c++) begin
                    r_table[s][c] <= '0;
                end
            end
        end else if (bus.cfg_we && w_step_ok && w_chan_ok) begin
            r_table[bus.cfg_step][bus.cfg_chan] <= bus.cfg_duty;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pre        <= '0;
            r_cnt        <= '0;
            r_frame_done <= 1'b0;
        end else if (w_off) begin
            r_pre        <= '0;
            r_cnt        <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_pre        <= w_tick ? '0 : r_pre + 1'b1;
            r_cnt        <= w_tick ? r_cnt + 1'b1 : r_cnt;
            r_frame_done <= w_wrap;
        end
    end

    // Step and ramp only advance while the same mode stays applied across a wrap;
    // any other transition yields zeros, which also clears them when leaving.
    always_comb begin
        w_step_next      = '0;
        w_fcnt_next      = '0;
        w_ramp_next      = '0;
        w_ramp_down_next = 1'b0;
        if (w_mode == MODE_SEQ && r_mode == MODE_SEQ) begin
            if (r_fcnt == bus.frames_per_step) begin
                w_step_next = (r_step == SW'(STEPS - 1)) ? '0 : r_step + 1'b1;
            end else begin
                w_fcnt_next = r_fcnt + 8'd1;
                w_step_next = r_step;
            end
        end
        if (w_mode == MODE_BREATHE && r_mode == MODE_BREATHE) begin
            w_ramp_next      = r_ramp;
            w_ramp_down_next = r_ramp_down;
            // At either endpoint only the direction flips, holding the value one more frame.
            if (!r_ramp_down) begin
                if (r_ramp == CNT_MAX) w_ramp_down_next = 1'b1;
                else                   w_ramp_next      = r_ramp + 1'b1;
            end else begin
                if (r_ramp == '0)      w_ramp_down_next = 1'b0;
                else                   w_ramp_next      = r_ramp - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mode      <= MODE_OFF;
            r_step      <= '0;
            r_fcnt      <= '0;
            r_ramp      <= '0;
            r_ramp_down <= 1'b0;
        end else if (w_off) begin
            r_mode      <= MODE_OFF;
            r_step      <= '0;
            r_fcnt      <= '0;
            r_ramp      <= '0;
            r_ramp_down <= 1'b0;
        end else if (w_wrap) begin
            r_mode      <= w_mode;
            r_step      <= w_step_next;
            r_fcnt      <= w_fcnt_next;
            r_ramp      <= w_ramp_next;
            r_ramp_down <= w_ramp_down_next;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        logic [2*PWM_WIDTH-1:0] w_prod;
        logic [PWM_WIDTH-1:0]   w_duty;

        assign w_prod = {{PWM_WIDTH{1'b0}}, r_table[0][c]} * {{PWM_WIDTH{1'b0}}, w_ramp_next};

        // Duty for the frame that starts at the coming wrap, under the mode applied there.
        always_comb begin
            w_duty = '0;
            case (w_mode)
                MODE_STATIC:  w_duty = r_table[0][c];
                MODE_SEQ:     w_duty = r_table[w_step_next][c];
                MODE_BREATHE: w_duty = PWM_WIDTH'(w_prod >> PWM_WIDTH);
                default:      w_duty = '0;
            endcase
        end

        led_pwm_channel #(
            .PWM_WIDTH(PWM_WIDTH)
        ) u_chan (
            .clk    (clk),
            .reset_n(reset_n),
            .i_en   (!w_off),
            .i_load (w_wrap),
            .i_duty (w_duty),
            .i_cnt  (r_cnt),
            .o_pwm  (w_pwm[c])
        );
    end

    assign bus.pwm_out    = w_pwm;
    assign bus.step_idx   = r_step;
    assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_led_pwm_seq.sv
// tb/tb_led_pwm_seq.sv - scoreboard bench for led_pwm_seq with a frame-level reference model
module tb_led_pwm_seq;
    import led_pwm_pkg::*;

    localparam int CH  = 3;
    localparam int PW  = 4;
    localparam int PSW = 16;
    localparam int ST  = 4;
    localparam int PER = 1 << PW;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    led_pwm_seq_if #(.CHANNELS(CH), .PWM_WIDTH(PW), .PRESCALE_WIDTH(PSW), .STEPS(ST)) bus ();

    led_pwm_seq #(.CHANNELS(CH), .PWM_WIDTH(PW), .PRESCALE_WIDTH(PSW), .STEPS(ST)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    int tab [ST][CH];
    int prev_mode = 0;
    int nfr = 0;
    int cur_p = 0;
    int cur_fps = 0;
    int q_step[$];
    int q_cnt[$];
    int n_checks = 0;
    int n_pass = 0;
    int acc [CH];
    int pend [CH];
    bit flush_req = 1'b0;
    int last_fd = -1;
    int cyc = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Reference: per frame, the high-clock count of each channel and the step index,
    // derived from frames elapsed since the mode was entered.
    task automatic push_expect(input int m);
        int step, k, ramp, d;
        if (m == prev_mode && (m == 2 || m == 3)) nfr++;
        else nfr = 0;
        prev_mode = m;
        step = (m == 2) ? (nfr / (cur_fps + 1)) % ST : 0;
        k    = nfr % (2 * PER);
        ramp = (k < PER) ? k : 2 * PER - 1 - k;
        q_step.push_back(step);
        for (int c = 0; c < CH; c++) begin
            case (m)
                1:       d = tab[0][c];
                2:       d = tab[step][c];
                3:       d = (tab[0][c] * ramp) >> PW;
                default: d = 0;
            endcase
            q_cnt.push_back(d * (cur_p + 1));
        end
    endtask

    task automatic set_mode(input int m);
        bus.mode = 2'(m);
        push_expect(m);
    endtask

    task automatic cfg_write(input int s, input int c, input int d);
        bus.cfg_we   = 1'b1;
        bus.cfg_step = 2'(s);
        bus.cfg_chan = 2'(c);
        bus.cfg_duty = 4'(d);
        @(posedge clk); #1;
        bus.cfg_we = 1'b0;
        if (s < ST && c < CH) tab[s][c] = d;
    endtask

    task automatic wait_frame();
        for (int k = 0; k < 2000; k++) begin
            @(posedge clk); #1;
            if (bus.frame_done) break;
        end
        if (!bus.frame_done) check("frame_seen", int'(bus.frame_done), 1);
    endtask

    task automatic go_off();
        bus.mode = MODE_OFF;
        repeat (2) begin @(posedge clk); #1; end
        flush_req = 1'b1;
        prev_mode = 0;
        @(posedge clk); #1;
    endtask

    task automatic enter(input int m);
        bus.prescale_div    = 16'(cur_p);
        bus.frames_per_step = 8'(cur_fps);
        set_mode(m);
    endtask

    // Monitor: accumulate high clocks, and at each frame_done close out the previous frame.
    always @(negedge clk) begin
        cyc++;
        if (flush_req) begin
            for (int c = 0; c < CH; c++) begin acc[c] = 0; pend[c] = 0; end
            last_fd   = -1;
            flush_req = 1'b0;
        end else if (reset_n) begin
            for (int c = 0; c < CH; c++) acc[c] += int'(bus.pwm_out[c]);
            if (bus.frame_done) begin
                for (int c = 0; c < CH; c++) begin
                    check($sformatf("frame_high_ch%0d", c), acc[c], pend[c]);
                    acc[c] = 0;
                end
                if (last_fd >= 0) check("frame_period", cyc - last_fd, PER * (cur_p + 1));
                last_fd = cyc;
                check("queue_has_entry", int'(q_step.size() > 0), 1);
                if (q_step.size() > 0) begin
                    check("step_idx", int'(bus.step_idx), q_step.pop_front());
                    for (int c = 0; c < CH; c++) pend[c] = q_cnt.pop_front();
                end else begin
                    for (int c = 0; c < CH; c++) pend[c] = 0;
                end
            end
        end
    end

    initial begin
        int m, nf;
        bus.mode = MODE_OFF; bus.prescale_div = '0; bus.frames_per_step = '0;
        bus.cfg_we = 1'b0; bus.cfg_step = '0; bus.cfg_chan = '0; bus.cfg_duty = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_pwm_out", int'(bus.pwm_out), 0);
        check("rst_step_idx", int'(bus.step_idx), 0);
        check("rst_frame_done", int'(bus.frame_done), 0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // STATIC {4,0,15}, mid-frame update, ignored write, write on the wrap clock.
        cfg_write(0, 0, 4); cfg_write(0, 1, 0); cfg_write(0, 2, 15);
        enter(1);
        wait_frame(); set_mode(1);
        wait_frame();
        cfg_write(0, 0, 8);
        cfg_write(0, 3, 9);
        set_mode(1);
        wait_frame();
        set_mode(1);
        repeat (15) @(posedge clk);
        #1;
        bus.cfg_we = 1'b1; bus.cfg_step = 2'd0; bus.cfg_chan = 2'd1; bus.cfg_duty = 4'd7;
        @(posedge clk); #1;
        bus.cfg_we = 1'b0;
        check("wrap_on_write_clock", int'(bus.frame_done), 1);
        tab[0][1] = 7;
        set_mode(1);
        wait_frame();
        repeat (4) @(posedge clk);
        #1;
        check("pwm2_high_before_off", int'(bus.pwm_out[2]), 1);
        bus.mode = MODE_OFF;
        @(posedge clk); #1;
        check("off_immediate", int'(bus.pwm_out), 0);
        go_off();

        // SEQ with two frames per step across all four steps.
        cur_p = 0; cur_fps = 1;
        for (int s = 1; s < ST; s++)
            for (int c = 0; c < CH; c++) cfg_write(s, c, $urandom_range(0, 15));
        enter(2);
        for (int j = 0; j < 10; j++) begin
            wait_frame();
            if (j < 9) set_mode(2);
        end
        go_off();

        // BREATHE through a full up/down ramp with full-scale table[0][0].
        cfg_write(0, 0, 15); cfg_write(0, 1, $urandom_range(1, 15));
        cur_fps = 0;
        enter(3);
        for (int j = 0; j < 35; j++) begin
            wait_frame();
            if (j < 34) set_mode(3);
        end
        go_off();

        // Asynchronous reset mid-frame while on step 1, then table must read back cleared.
        for (int c = 0; c < CH; c++) cfg_write(1, c, 15);
        enter(2);
        wait_frame(); set_mode(2);
        wait_frame();
        repeat (3) @(posedge clk);
        #1;
        check("pwm_high_before_reset", int'(bus.pwm_out), 7);
        reset_n = 1'b0;
        #1;
        check("async_rst_pwm_out", int'(bus.pwm_out), 0);
        check("async_rst_step_idx", int'(bus.step_idx), 0);
        check("async_rst_frame_done", int'(bus.frame_done), 0);
        bus.mode = MODE_OFF;
        prev_mode = 0;
        for (int s = 0; s < ST; s++) for (int c = 0; c < CH; c++) tab[s][c] = 0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        flush_req = 1'b1;
        @(posedge clk); #1;
        enter(1);
        wait_frame(); set_mode(1);
        wait_frame();
        go_off();

        // Randomized segments: prescaler, frames_per_step, table writes and mode changes.
        for (int seg = 0; seg < 6; seg++) begin
            cur_p   = $urandom_range(0, 2);
            cur_fps = $urandom_range(0, 2);
            for (int w = 0; w < 4; w++)
                cfg_write($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 15));
            m = $urandom_range(1, 3);
            enter(m);
            nf = $urandom_range(6, 14);
            for (int j = 0; j < nf; j++) begin
                wait_frame();
                if (j < nf - 1) begin
                    repeat ($urandom_range(0, 2))
                        cfg_write($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 15));
                    if ($urandom_range(0, 3) == 0) m = $urandom_range(1, 3);
                    set_mode(m);
                end
            end
            go_off();
        end

        check("queue_drained", q_step.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
